ahb_lite_sram_slave: RTL
========================

Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder: a word-organised on-chip SRAM that services transfers issued by the bus master fed from the transaction FIFO.
- Decodes the address phase, runs the data phase with optional wait states and byte-lane writes.
- Returns OKAY, or a two-cycle ERROR for out-of-range, misaligned or reserved-size accesses.
- Sits on the slave side of the AHB-Lite interconnect; widths follow `BUS_WIDTH (32) from AHB_Lite_defines.v.

Parameters:
- MEM_DEPTH: default 256. Number of 32-bit words; the valid byte range is 0 to MEM_DEPTH*4-1.
- WAIT_CYCLES: default 2. Data-phase wait states per OKAY transfer; used only when AHB_SLAVE_WAIT_EN is defined.

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- resetn  in  1  asynchronous reset, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  `BUS_WIDTH  byte address, address phase.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write, 0=read, address phase.
- HSIZE  in  2  `Byte=0, `Halfword=1, `Word=2; the value 3 is reserved.
- HWDATA  in  `BUS_WIDTH  write data, data phase.
- HREADY  in  1  bus-level ready; the previous transfer is complete.
- HRDATA  out  `BUS_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Outputs: HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM goes to IDLE, all captured address-phase registers clear, and any pending write is dropped.
  - Memory contents are not reset.
- Accept: an address phase is accepted at a posedge when HSEL=1, HTRANS[1]=1 and HREADY=1. The block latches HADDR, HWRITE and HSIZE.
- IDLE/BUSY transfers, or HSEL=0: no action. HREADYOUT=1, HRESP=0 on the following cycle.
- Error checks, evaluated at accept:
  - HADDR >= MEM_DEPTH*4;
  - HSIZE=3;
  - Halfword with HADDR[0]=1;
  - Word with HADDR[1:0]!=0.
  - Any of these leads to ERR1 then ERR2, and no memory access happens.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted OK transfer goes to DATA (or WAIT if the wait count is >0); accepted bad transfer goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. A counter loads WAIT_CYCLES at accept and decrements each cycle; at 0 the FSM goes to DATA.
  - DATA: HREADYOUT=1, HRESP=0.
    - Write: HWDATA is sampled at the closing edge. Byte enables come from the latched HADDR[1:0] and HSIZE, little-endian. Byte 0 uses lane [7:0]; halfword at addr[1]=1 uses lane [31:16].
    - Read: HRDATA = full addressed word for the whole DATA cycle; the master selects the lane.
    - Next state: a new accept at the closing edge starts the next transfer back-to-back (DATA, WAIT or ERR1); otherwise IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, lasts one cycle, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. An accept at this edge is handled as from DATA; otherwise IDLE.
- Latency:
  - Zero wait states: data phase completes 1 cycle after accept.
  - With wait states: completes WAIT_CYCLES+1 cycles after accept.
- Read-after-write to the same word, back-to-back: the read's HRDATA must reflect the merged bytes of the just-completed write (forwarding); no stale data.
- HRDATA outside a read DATA cycle holds its last value. It is don't-care to the bench.
- resetn asserted mid-WAIT or mid-ERR1: the transfer is abandoned and outputs return to reset values immediately.

Optional Feature:
- Macro: AHB_SLAVE_WAIT_EN.
- Defined: every OKAY transfer inserts WAIT_CYCLES cycles of HREADYOUT=0 before DATA. WAIT_CYCLES=0 behaves as zero-wait.
- Undefined: the WAIT state and counter are not built, WAIT_CYCLES is ignored, and every OKAY transfer is zero-wait.
- ERROR timing is identical in both builds.

Test Plan:
- Build: feature undefined unless stated.
- Write word 0x12345678 @0x4, then read 0x4 -> read DATA cycle gives HRDATA=0x12345678, HRESP=0, HREADYOUT=1 one cycle after accept.
- Halfword write 0x00FF @0x2 over word 0x12345678 @0x0, then word read @0x0 -> HRDATA=0x00FF5678.
- Back-to-back: byte write 0xAA @0x8, with read @0x8 accepted at the write's closing edge -> HRDATA[7:0]=0xAA (forwarding), no wait.
- Byte write @0x00002000 (MEM_DEPTH=256) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), memory unchanged. Halfword @0x1 and HSIZE=3 @0x0 -> same ERROR.
- AHB_SLAVE_WAIT_EN defined, WAIT_CYCLES=2, read @0x4 -> HREADYOUT low for exactly 2 cycles, then high with correct HRDATA. resetn=0 during the 2nd wait cycle -> HREADYOUT=1, HRESP=0 immediately, and no completion reported.
- HTRANS=IDLE with HSEL=1 @0x4, HWRITE=1 -> OKAY, zero-wait, memory @0x4 unchanged.

Source files
------------

// File: rtl/ahb_lite_sram_slave_if.sv
// rtl/ahb_lite_sram_slave_if.sv - AHB-Lite bus bundle between a master/interconnect and ahb_lite_sram_slave
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

interface ahb_lite_sram_slave_if;
  logic                  HSEL;
  logic [`BUS_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [1:0]            HSIZE;
  logic [`BUS_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [`BUS_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite word SRAM responder with byte-lane writes and two-cycle ERROR
// Optional data-phase wait states are built when AHB_SLAVE_WAIT_EN is defined.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_lite_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 HCLK,
  input  logic                 resetn,
  ahb_lite_sram_slave_if.slave bus
);
  localparam int            BW        = `BUS_WIDTH;
  localparam int            IW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [BW-1:0] MEM_BYTES = BW'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state_q, state_d;
  logic [IW+1:0]   addr_q;
  logic            write_q;
  logic [1:0]      size_q;
  logic [BW-1:0]   hrdata_q;
  logic [BW-1:0]   mem [MEM_DEPTH];

  logic            accept, take, bad;
  logic            wr_en, rd_load, rd_is_read;
  logic [3:0]      be;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [BW-1:0]   wr_word, rd_word;

  assign accept = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
  assign take   = accept && (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2);
  assign bad    = (bus.HADDR >= MEM_BYTES) || (bus.HSIZE == 2'd3) ||
                  (bus.HSIZE == 2'd1 && bus.HADDR[0]) ||
                  (bus.HSIZE == 2'd2 && bus.HADDR[1:0] != 2'b00);

`ifdef AHB_SLAVE_WAIT_EN
  localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYCLES);
  logic [15:0] wait_q, wait_d;

  always_ff @(posedge HCLK or negedge resetn) begin
    if (!resetn) wait_q <= '0;
    else         wait_q <= wait_d;
  end
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^WAIT_CYCLES;
`endif

  logic unused_htrans0;
  assign unused_htrans0 = bus.HTRANS[0];

  always_comb begin
    state_d = state_q;
`ifdef AHB_SLAVE_WAIT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          if (bad) begin
            state_d = S_ERR1;
          end
`ifdef AHB_SLAVE_WAIT_EN
          else if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            wait_d  = WAIT_LOAD;
          end
`endif
          else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef AHB_SLAVE_WAIT_EN
      S_WAIT: begin
        wait_d = wait_q - 16'd1;
        if (wait_q == 16'd1) state_d = S_DATA;
      end
`endif
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign wr_idx = addr_q[IW+1:2];
  assign wr_en  = (state_q == S_DATA) && write_q;

  always_comb begin
    wr_word = mem[wr_idx];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
  end

  // A read entering DATA on the same edge a write to its word completes takes the merged word.
  assign rd_idx     = (state_q == S_WAIT) ? addr_q[IW+1:2] : bus.HADDR[IW+1:2];
  assign rd_is_read = (state_q == S_WAIT) ? !write_q : !bus.HWRITE;
  assign rd_load    = (state_d == S_DATA) && rd_is_read;
  assign rd_word    = (wr_en && wr_idx == rd_idx) ? wr_word : mem[rd_idx];

  always_ff @(posedge HCLK) begin
    if (wr_en && resetn) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge HCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= bus.HADDR[IW+1:0];
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
      end
      if (rd_load) hrdata_q <= rd_word;
    end
  end

  assign bus.HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign bus.HRESP     = (state_q == S_ERR1 || state_q == S_ERR2);
  assign bus.HRDATA    = hrdata_q;
endmodule
